// File: rtl/rmt_parser_pkg.sv
// Shared parser definitions: scheduler FSM states, default tag width, bundle width helper.
package rmt_parser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_t;

    localparam int unsigned C_TAG_WIDTH_DEF = 8;

    function automatic int unsigned bundle_width(input int unsigned data_w, input int unsigned num_segs);
        return data_w * num_segs;
    endfunction

endpackage

// File: rtl/parser_rr_arb.sv
// Combinational rotating-priority arbiter: first unmasked requester at/after rr_ptr, wrapping.
module parser_rr_arb #(
    parameter  int unsigned C_NUM_ENGINES = 4,
    localparam int unsigned C_IDX_W       = (C_NUM_ENGINES > 1) ? $clog2(C_NUM_ENGINES) : 1
) (
    input  logic [C_NUM_ENGINES-1:0] i_req,
    input  logic [C_NUM_ENGINES-1:0] i_mask,
    input  logic [C_IDX_W-1:0]       i_rr_ptr,
    output logic [C_NUM_ENGINES-1:0] o_grant_c,
    output logic [C_IDX_W-1:0]       o_idx_c,
    output logic                     o_any_c
);

    logic [C_NUM_ENGINES-1:0] w_eff;
    logic [C_IDX_W-1:0]       w_cand;

    always_comb begin
        w_eff     = i_req & ~i_mask;
        w_cand    = '0;
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        for (int unsigned k = 0; k < C_NUM_ENGINES; k++) begin
            w_cand = C_IDX_W'((32'(i_rr_ptr) + k) % C_NUM_ENGINES);
            if (!o_any_c && w_eff[w_cand]) begin
                o_any_c           = 1'b1;
                o_grant_c[w_cand] = 1'b1;
                o_idx_c           = w_cand;
            end
        end
    end

endmodule

// File: rtl/parser_segs_sched.sv
// Bundle FIFO plus round-robin dispatch to parser engines with sequence tagging.
// Optional statistics counters are enabled by defining PARSER_SCHED_STATS_EN.
module parser_segs_sched
    import rmt_parser_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_NUM_SEGS         = 2,
    parameter int unsigned C_NUM_ENGINES      = 4,
    parameter int unsigned C_FIFO_DEPTH       = 8,
    parameter int unsigned C_TAG_WIDTH        = C_TAG_WIDTH_DEF
) (
    input  logic                                   axis_clk,
    input  logic                                   aresetn,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in_data,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]          segs_in_tuser,
    input  logic                                   segs_in_valid,
    output logic                                   segs_fifo_ready,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] eng_data,
    output logic [C_AXIS_TUSER_WIDTH-1:0]          eng_tuser,
    output logic [C_TAG_WIDTH-1:0]                 eng_tag,
    output logic [C_NUM_ENGINES-1:0]               eng_valid,
    input  logic [C_NUM_ENGINES-1:0]               eng_ready,
`ifdef PARSER_SCHED_STATS_EN
    input  logic                                   stat_clear,
    output logic [31:0]                            stat_dispatched,
    output logic [31:0]                            stat_dropped,
`endif
    output logic                                   drop_pulse
);

    localparam int unsigned C_BUNDLE_W = bundle_width(C_AXIS_DATA_WIDTH, C_NUM_SEGS);
    localparam int unsigned C_AW       = $clog2(C_FIFO_DEPTH);
    localparam int unsigned C_IW       = $clog2(C_NUM_ENGINES);

    logic [C_BUNDLE_W-1:0]         r_mem_data  [C_FIFO_DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] r_mem_tuser [C_FIFO_DEPTH];
    logic [C_AW:0]                 r_wr_ptr;
    logic [C_AW:0]                 r_rd_ptr;
    sched_state_t                  r_state;
    logic [C_IW-1:0]               r_rr_ptr;
    logic [C_TAG_WIDTH-1:0]        r_tag;
    logic [C_BUNDLE_W-1:0]         r_eng_data;
    logic [C_AXIS_TUSER_WIDTH-1:0] r_eng_tuser;
    logic [C_TAG_WIDTH-1:0]        r_eng_tag;
    logic [C_NUM_ENGINES-1:0]      r_eng_valid;
    logic                          r_ready;
    logic                          r_drop;

    logic [C_AW:0]                 w_occ;
    logic [C_AW:0]                 w_occ_next;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_xfer;
    logic                          w_pop;
    logic                          w_wr;
    logic                          w_drop;
    logic [C_NUM_ENGINES-1:0]      w_mask;
    logic [C_NUM_ENGINES-1:0]      w_grant;
    logic [C_IW-1:0]               w_sel;
    logic                          w_any;
    logic [C_IW-1:0]               w_rr_next;

    // While offering, the engine already holding the offer cannot take the next bundle.
    assign w_mask = (r_state == ST_OFFER) ? r_eng_valid : '0;

    parser_rr_arb #(
        .C_NUM_ENGINES (C_NUM_ENGINES)
    ) u_arb (
        .i_req     (eng_ready),
        .i_mask    (w_mask),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_sel),
        .o_any_c   (w_any)
    );

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_occ == '0);
    assign w_full     = (w_occ == (C_AW+1)'(C_FIFO_DEPTH));
    assign w_xfer     = (r_state == ST_OFFER) && (|(r_eng_valid & eng_ready));
    assign w_pop      = !w_empty && w_any && ((r_state == ST_IDLE) || w_xfer);
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    assign w_wr       = segs_in_valid && (!w_full || w_pop);
    assign w_drop     = segs_in_valid && w_full && !w_pop;
    assign w_occ_next = w_occ + (C_AW+1)'(w_wr) - (C_AW+1)'(w_pop);
    assign w_rr_next  = (w_sel == C_IW'(C_NUM_ENGINES-1)) ? '0 : w_sel + C_IW'(1);

    // Bundle storage needs no reset; pointers define validity.
    always_ff @(posedge axis_clk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr[C_AW-1:0]]  <= segs_in_data;
            r_mem_tuser[r_wr_ptr[C_AW-1:0]] <= segs_in_tuser;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_tag       <= '0;
            r_eng_data  <= '0;
            r_eng_tuser <= '0;
            r_eng_tag   <= '0;
            r_eng_valid <= '0;
            r_ready     <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_ready <= (w_occ_next <= (C_AW+1)'(C_FIFO_DEPTH-2));
            r_drop  <= w_drop;
            if (w_wr) r_wr_ptr <= r_wr_ptr + (C_AW+1)'(1);
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + (C_AW+1)'(1);
                r_eng_data  <= r_mem_data[r_rd_ptr[C_AW-1:0]];
                r_eng_tuser <= r_mem_tuser[r_rd_ptr[C_AW-1:0]];
                r_eng_tag   <= r_tag;
                r_tag       <= r_tag + C_TAG_WIDTH'(1);
                r_eng_valid <= w_grant;
                r_rr_ptr    <= w_rr_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) r_state <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (w_xfer && !w_pop) begin
                        r_eng_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign segs_fifo_ready = r_ready;
    assign eng_data        = r_eng_data;
    assign eng_tuser       = r_eng_tuser;
    assign eng_tag         = r_eng_tag;
    assign eng_valid       = r_eng_valid;
    assign drop_pulse      = r_drop;

`ifdef PARSER_SCHED_STATS_EN
    logic [31:0] r_stat_disp;
    logic [31:0] r_stat_drop;

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge axis_clk) begin
        if (!aresetn || stat_clear) begin
            r_stat_disp <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_xfer && (r_stat_disp != '1)) r_stat_disp <= r_stat_disp + 32'd1;
            if (w_drop && (r_stat_drop != '1)) r_stat_drop <= r_stat_drop + 32'd1;
        end
    end

    assign stat_dispatched = r_stat_disp;
    assign stat_dropped    = r_stat_drop;
`endif

endmodule

// File: tb/tb_parser_segs_sched.sv
// Directed self-checking bench for parser_segs_sched (default parameters).
module tb_parser_segs_sched;

    logic          axis_clk = 1'b0;
    logic          aresetn  = 1'b0;
    logic [1023:0] segs_in_data  = '0;
    logic [127:0]  segs_in_tuser = '0;
    logic          segs_in_valid = 1'b0;
    logic          segs_fifo_ready;
    logic [1023:0] eng_data;
    logic [127:0]  eng_tuser;
    logic [7:0]    eng_tag;
    logic [3:0]    eng_valid;
    logic [3:0]    eng_ready = '0;
    logic          drop_pulse;
`ifdef PARSER_SCHED_STATS_EN
    logic          stat_clear = 1'b0;
    logic [31:0]   stat_dispatched;
    logic [31:0]   stat_dropped;
`endif

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    logic [3:0]    mq_sel  [$];
    logic [7:0]    mq_tag  [$];
    logic [1023:0] mq_data [$];
    int unsigned   mq_cyc  [$];

    parser_segs_sched dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .segs_in_data    (segs_in_data),
        .segs_in_tuser   (segs_in_tuser),
        .segs_in_valid   (segs_in_valid),
        .segs_fifo_ready (segs_fifo_ready),
        .eng_data        (eng_data),
        .eng_tuser       (eng_tuser),
        .eng_tag         (eng_tag),
        .eng_valid       (eng_valid),
        .eng_ready       (eng_ready),
`ifdef PARSER_SCHED_STATS_EN
        .stat_clear      (stat_clear),
        .stat_dispatched (stat_dispatched),
        .stat_dropped    (stat_dropped),
`endif
        .drop_pulse      (drop_pulse)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    // Record every transfer (valid and ready on the selected engine at the upcoming edge).
    always @(negedge axis_clk) begin
        if (aresetn && (|(eng_valid & eng_ready))) begin
            mq_sel.push_back(eng_valid);
            mq_tag.push_back(eng_tag);
            mq_data.push_back(eng_data);
            mq_cyc.push_back(cyc);
        end
    end

    function automatic logic [1023:0] mk_data(input int unsigned i);
        logic [1023:0] d;
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = 32'(i * 32'h01010101 + 32'(k));
        return d;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push(input int unsigned i);
        tick();
        segs_in_valid = 1'b1;
        segs_in_data  = mk_data(i);
        segs_in_tuser = 128'(i);
    endtask

    task automatic idle();
        tick();
        segs_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        segs_in_valid = 1'b0;
        eng_ready     = '0;
        aresetn       = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        mq_sel.delete();
        mq_tag.delete();
        mq_data.delete();
        mq_cyc.delete();
    endtask

    task automatic wait_deliveries(input int n, input int budget, input string name);
        int k = 0;
        while (mq_sel.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (mq_sel.size() < n) begin
            $display("FAIL %s timeout: deliveries=%0d required=%0d", name, mq_sel.size(), n);
            failures++;
        end
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        eng_ready = '0;
        tick();
        tick();
        tick();
        @(negedge axis_clk);
        checks++; if (segs_fifo_ready !== 1'b0) begin $display("FAIL reset_ready got=%b exp=0", segs_fifo_ready); failures++; end
        checks++; if (eng_valid !== 4'b0) begin $display("FAIL reset_valid got=%b exp=0000", eng_valid); failures++; end
        checks++; if (drop_pulse !== 1'b0) begin $display("FAIL reset_drop got=%b exp=0", drop_pulse); failures++; end
        checks++; if (eng_tag !== 8'd0) begin $display("FAIL reset_tag got=%0d exp=0", eng_tag); failures++; end
        tick();
        aresetn = 1'b1;
        tick();
        @(negedge axis_clk);
        checks++; if (segs_fifo_ready !== 1'b1) begin $display("FAIL reset_ready_after got=%b exp=1", segs_fifo_ready); failures++; end
    endtask

    task automatic test_single();
        do_reset();
        eng_ready = 4'hF;
        push(100);
        idle();
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0000) begin $display("FAIL single_t1 got=%b exp=0000", eng_valid); failures++; end
        tick();
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0001) begin $display("FAIL single_t2_valid got=%b exp=0001", eng_valid); failures++; end
        checks++; if (eng_tag !== 8'd0) begin $display("FAIL single_tag got=%0d exp=0", eng_tag); failures++; end
        checks++; if (eng_data !== mk_data(100)) begin $display("FAIL single_data got=%h", eng_data); failures++; end
        checks++; if (eng_tuser !== 128'd100) begin $display("FAIL single_tuser got=%0d exp=100", eng_tuser); failures++; end
        tick();
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0000) begin $display("FAIL single_idle got=%b exp=0000", eng_valid); failures++; end
    endtask

    task automatic test_back_to_back();
        do_reset();
        eng_ready = 4'hF;
        for (int i = 0; i < 6; i++) push(200 + i);
        idle();
        wait_deliveries(6, 40, "b2b");
        for (int i = 0; i < 6 && i < mq_sel.size(); i++) begin
            checks++; if (mq_sel[i] !== 4'(1 << (i % 4))) begin $display("FAIL b2b_sel[%0d] got=%b exp=%b", i, mq_sel[i], 4'(1 << (i % 4))); failures++; end
            checks++; if (mq_tag[i] !== 8'(i)) begin $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", i, mq_tag[i], i); failures++; end
            checks++; if (mq_data[i] !== mk_data(200 + i)) begin $display("FAIL b2b_data[%0d] got=%h", i, mq_data[i]); failures++; end
            if (i > 0) begin
                checks++; if (mq_cyc[i] - mq_cyc[i-1] !== 1) begin $display("FAIL b2b_spacing[%0d] got=%0d exp=1", i, mq_cyc[i] - mq_cyc[i-1]); failures++; end
            end
        end
    endtask

    task automatic test_single_engine();
        do_reset();
        eng_ready = 4'b0100;
        for (int i = 0; i < 3; i++) push(250 + i);
        idle();
        wait_deliveries(3, 40, "eng2");
        for (int i = 0; i < 3 && i < mq_sel.size(); i++) begin
            checks++; if (mq_sel[i] !== 4'b0100) begin $display("FAIL eng2_sel[%0d] got=%b exp=0100", i, mq_sel[i]); failures++; end
            checks++; if (mq_data[i] !== mk_data(250 + i)) begin $display("FAIL eng2_data[%0d] got=%h", i, mq_data[i]); failures++; end
            checks++; if (mq_tag[i] !== 8'(i)) begin $display("FAIL eng2_tag[%0d] got=%0d exp=%0d", i, mq_tag[i], i); failures++; end
            if (i > 0) begin
                checks++; if (mq_cyc[i] - mq_cyc[i-1] !== 2) begin $display("FAIL eng2_spacing[%0d] got=%0d exp=2", i, mq_cyc[i] - mq_cyc[i-1]); failures++; end
            end
        end
    endtask

    task automatic test_backpressure_drop();
        int   sent;
        int   occ;
        logic prev_rdy;
        logic wr_now;
        do_reset();
        sent = 0;
        @(negedge axis_clk);
        prev_rdy = segs_fifo_ready;
        // Collector model: emits only in the cycle after it saw ready.
        for (int c = 0; c < 14; c++) begin
            tick();
            wr_now = prev_rdy && (sent < 10);
            segs_in_valid = wr_now;
            if (wr_now) begin
                segs_in_data  = mk_data(300 + sent);
                segs_in_tuser = 128'(300 + sent);
                sent++;
            end
            @(negedge axis_clk);
            occ = sent - (wr_now ? 1 : 0);
            checks++; if (segs_fifo_ready !== (occ <= 6)) begin $display("FAIL bp_ready c=%0d occ=%0d got=%b exp=%b", c, occ, segs_fifo_ready, (occ <= 6)); failures++; end
            checks++; if (drop_pulse !== 1'b0) begin $display("FAIL bp_nodrop c=%0d got=%b exp=0", c, drop_pulse); failures++; end
            prev_rdy = segs_fifo_ready;
        end
        checks++; if (sent !== 8) begin $display("FAIL bp_accepted got=%0d exp=8", sent); failures++; end
        push(999);
        idle();
        @(negedge axis_clk);
        checks++; if (drop_pulse !== 1'b1) begin $display("FAIL drop_pulse got=%b exp=1", drop_pulse); failures++; end
`ifdef PARSER_SCHED_STATS_EN
        checks++; if (stat_dropped !== 32'd1) begin $display("FAIL stat_dropped got=%0d exp=1", stat_dropped); failures++; end
`endif
        tick();
        @(negedge axis_clk);
        checks++; if (drop_pulse !== 1'b0) begin $display("FAIL drop_one_cycle got=%b exp=0", drop_pulse); failures++; end
        eng_ready = 4'hF;
        wait_deliveries(8, 60, "bp_release");
        for (int k = 0; k < 5; k++) tick();
        checks++; if (mq_sel.size() !== 8) begin $display("FAIL bp_count got=%0d exp=8", mq_sel.size()); failures++; end
        for (int i = 0; i < 8 && i < mq_sel.size(); i++) begin
            checks++; if (mq_data[i] !== mk_data(300 + i)) begin $display("FAIL bp_data[%0d] got=%h", i, mq_data[i]); failures++; end
            checks++; if (mq_tag[i] !== 8'(i)) begin $display("FAIL bp_tag[%0d] got=%0d exp=%0d", i, mq_tag[i], i); failures++; end
            checks++; if (mq_sel[i] !== 4'(1 << (i % 4))) begin $display("FAIL bp_sel[%0d] got=%b exp=%b", i, mq_sel[i], 4'(1 << (i % 4))); failures++; end
        end
`ifdef PARSER_SCHED_STATS_EN
        @(negedge axis_clk);
        checks++; if (stat_dispatched !== 32'd8) begin $display("FAIL stat_dispatched got=%0d exp=8", stat_dispatched); failures++; end
        tick();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        @(negedge axis_clk);
        checks++; if (stat_dispatched !== 32'd0 || stat_dropped !== 32'd0) begin $display("FAIL stat_clear got=%0d/%0d exp=0/0", stat_dispatched, stat_dropped); failures++; end
`endif
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        for (int i = 0; i < 4; i++) push(400 + i);
        idle();
        tick();
        eng_ready = 4'b0010;
        tick();
        eng_ready = 4'b0000;
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0010) begin $display("FAIL offer_valid got=%b exp=0010", eng_valid); failures++; end
        tick();
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0010 || eng_data !== mk_data(400)) begin $display("FAIL offer_hold valid=%b data=%h", eng_valid, eng_data); failures++; end
        aresetn = 1'b0;
        tick();
        @(negedge axis_clk);
        checks++; if (eng_valid !== 4'b0000) begin $display("FAIL midrst_valid got=%b exp=0000", eng_valid); failures++; end
        checks++; if (eng_tag !== 8'd0) begin $display("FAIL midrst_tag got=%0d exp=0", eng_tag); failures++; end
        tick();
        aresetn = 1'b1;
        tick();
        mq_sel.delete(); mq_tag.delete(); mq_data.delete(); mq_cyc.delete();
        eng_ready = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (mq_sel.size() !== 0) begin $display("FAIL midrst_fifo_empty got=%0d exp=0", mq_sel.size()); failures++; end
        push(410);
        idle();
        wait_deliveries(1, 20, "midrst_after");
        if (mq_sel.size() > 0) begin
            checks++; if (mq_sel[0] !== 4'b0001) begin $display("FAIL midrst_rr got=%b exp=0001", mq_sel[0]); failures++; end
            checks++; if (mq_tag[0] !== 8'd0) begin $display("FAIL midrst_tag0 got=%0d exp=0", mq_tag[0]); failures++; end
            checks++; if (mq_data[0] !== mk_data(410)) begin $display("FAIL midrst_data got=%h", mq_data[0]); failures++; end
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        eng_ready = 4'hF;
        for (int i = 0; i < 257; i++) push(1000 + i);
        idle();
        wait_deliveries(257, 600, "wrap");
        for (int i = 0; i < 257 && i < mq_sel.size(); i++) begin
            checks++; if (mq_tag[i] !== 8'(i)) begin $display("FAIL wrap_tag[%0d] got=%0d exp=%0d", i, mq_tag[i], 8'(i)); failures++; end
            checks++; if (mq_data[i] !== mk_data(1000 + i)) begin $display("FAIL wrap_data[%0d] got=%h", i, mq_data[i]); failures++; end
        end
`ifdef PARSER_SCHED_STATS_EN
        @(negedge axis_clk);
        checks++; if (stat_dispatched !== 32'd257) begin $display("FAIL wrap_stat got=%0d exp=257", stat_dispatched); failures++; end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_single_engine();
        test_backpressure_drop();
        test_reset_mid_offer();
        test_tag_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
